dual_port_ram_arb: RTL and testbench

Single-clock dual-port RAM with two independent read/write ports, A and B, and a per-word used flag. When both ports write the same address in the same cycle, the block resolves the collision instead of corrupting data. Port A keeps its address. Port B's write is redirected to the next free word. It sits between two producers that share one buffer and must never silently lose a write.

---
 rtl/dual_port_ram_arb_if.sv | 39 +++
 rtl/dual_port_ram_arb.sv | 106 ++++++++++
 tb/tb_dual_port_ram_arb.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_port_ram_arb_if.sv
// Bus bundle for dual_port_ram_arb.
// Purpose: groups both ports' strobes, addresses and data with the arbitration status outputs.
// Signals:
//   write_enable_a/b, output_enable_a/b : write/read strobes per port
//   address_a/b, data_in_a/b            : word address and write data per port
//   data_out_a/b                        : registered read data per port
//   redirect_b, redirect_addr_b         : B write was moved, and the address it landed on
//   drop_b                              : B write discarded on a conflict with no free word
// Modports: master drives requests (producer/bench side), slave is the RAM.
interface dual_port_ram_arb_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  write_enable_a;
    logic                  write_enable_b;
    logic                  output_enable_a;
    logic                  output_enable_b;
    logic [ADDR_WIDTH-1:0] address_a;
    logic [ADDR_WIDTH-1:0] address_b;
    logic [DATA_WIDTH-1:0] data_in_a;
    logic [DATA_WIDTH-1:0] data_in_b;
    logic [DATA_WIDTH-1:0] data_out_a;
    logic [DATA_WIDTH-1:0] data_out_b;
    logic                  redirect_b;
    logic [ADDR_WIDTH-1:0] redirect_addr_b;
    logic                  drop_b;

    modport master (
        output write_enable_a, write_enable_b, output_enable_a, output_enable_b,
        output address_a, address_b, data_in_a, data_in_b,
        input  data_out_a, data_out_b, redirect_b, redirect_addr_b, drop_b
    );

    modport slave (
        input  write_enable_a, write_enable_b, output_enable_a, output_enable_b,
        input  address_a, address_b, data_in_a, data_in_b,
        output data_out_a, data_out_b, redirect_b, redirect_addr_b, drop_b
    );
endinterface

// File: rtl/dual_port_ram_arb.sv
// Single-clock dual-port RAM with per-word used flags and same-address write arbitration.
// When both ports write one address in the same cycle, A keeps it and B is moved to the
// first unused word above it (wrapping); if none is free, B's write is dropped.
// Ports:
//   clk   : single clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset (clears used flags and outputs, not memory)
//   bus   : dual_port_ram_arb_if slave modport carrying both ports and status outputs
module dual_port_ram_arb #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    dual_port_ram_arb_if.slave bus
);
    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] memory [Depth];
    logic [Depth-1:0]      used_flag;

    logic [DATA_WIDTH-1:0] data_out_a_q;
    logic [DATA_WIDTH-1:0] data_out_b_q;
    logic                  redirect_b_q;
    logic [ADDR_WIDTH-1:0] redirect_addr_b_q;
    logic                  drop_b_q;

    logic                  conflict;
    logic                  free_found;
    logic [ADDR_WIDTH-1:0] free_addr;
    logic [ADDR_WIDTH-1:0] cand;
    logic                  b_write;
    logic [ADDR_WIDTH-1:0] b_addr;

    always_comb begin
        conflict = bus.write_enable_a && bus.write_enable_b &&
                   (bus.address_a == bus.address_b);
    end

    // First unused word strictly above address_b, wrapping; address_b itself is never a
    // candidate. Flags are the pre-edge values, so this edge's writes do not affect it.
    always_comb begin
        free_found = 1'b0;
        free_addr  = '0;
        cand       = '0;
        for (int unsigned i = 1; i < Depth; i++) begin
            cand = bus.address_b + ADDR_WIDTH'(i);
            if (!free_found && !used_flag[cand]) begin
                free_found = 1'b1;
                free_addr  = cand;
            end
        end
    end

    always_comb begin
        b_write = bus.write_enable_b && (!conflict || free_found);
        b_addr  = conflict ? free_addr : bus.address_b;
    end

    // Storage is deliberately left out of reset; only the request is gated by it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (bus.write_enable_a) begin
                memory[bus.address_a] <= bus.data_in_a;
            end
            if (b_write) begin
                memory[b_addr] <= bus.data_in_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            used_flag         <= '0;
            data_out_a_q      <= '0;
            data_out_b_q      <= '0;
            redirect_b_q      <= 1'b0;
            redirect_addr_b_q <= '0;
            drop_b_q          <= 1'b0;
        end else begin
            if (bus.write_enable_a) begin
                used_flag[bus.address_a] <= 1'b1;
            end
            if (b_write) begin
                used_flag[b_addr] <= 1'b1;
            end
            // Read-first: the nonblocking array read returns the pre-edge word.
            if (bus.output_enable_a && !bus.write_enable_a) begin
                data_out_a_q <= memory[bus.address_a];
            end
            if (bus.output_enable_b && !bus.write_enable_b) begin
                data_out_b_q <= memory[bus.address_b];
            end
            redirect_b_q <= conflict && free_found;
            drop_b_q     <= conflict && !free_found;
            if (conflict && free_found) begin
                redirect_addr_b_q <= free_addr;
            end
        end
    end

    assign bus.data_out_a      = data_out_a_q;
    assign bus.data_out_b      = data_out_b_q;
    assign bus.redirect_b      = redirect_b_q;
    assign bus.redirect_addr_b = redirect_addr_b_q;
    assign bus.drop_b          = drop_b_q;
endmodule

// File: tb/tb_dual_port_ram_arb.sv
// Self-checking bench for dual_port_ram_arb: a word-level reference model (arrays of
// words and used bits) is stepped on every rising edge and compared against the DUT's
// outputs on every falling edge; directed scenarios add literal expectations.
module tb_dual_port_ram_arb;
    localparam int DEPTH = 256;

    logic clk;
    logic rst_n;

    dual_port_ram_arb_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    dual_port_ram_arb #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    logic [7:0] mem_m  [DEPTH];
    bit         used_m [DEPTH];
    logic [7:0] exp_dout_a, exp_dout_b, exp_raddr;
    logic       exp_redir, exp_drop;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Applies the specification's rules to the inputs present at this edge.
    task automatic model_step();
        int  free_idx;
        bit  conflict;
        int  a, b;
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) used_m[i] = 1'b0;
            exp_dout_a = 8'h00;
            exp_dout_b = 8'h00;
            exp_raddr  = 8'h00;
            exp_redir  = 1'b0;
            exp_drop   = 1'b0;
            return;
        end
        a = int'(bus.address_a);
        b = int'(bus.address_b);
        exp_redir = 1'b0;
        exp_drop  = 1'b0;
        if (bus.output_enable_a && !bus.write_enable_a) exp_dout_a = mem_m[a];
        if (bus.output_enable_b && !bus.write_enable_b) exp_dout_b = mem_m[b];
        conflict = bus.write_enable_a && bus.write_enable_b && (a == b);
        free_idx = -1;
        if (conflict) begin
            for (int k = 1; k < DEPTH; k++) begin
                if (free_idx < 0 && !used_m[(b + k) % DEPTH]) free_idx = (b + k) % DEPTH;
            end
        end
        if (bus.write_enable_a) begin
            mem_m[a]  = bus.data_in_a;
            used_m[a] = 1'b1;
        end
        if (bus.write_enable_b) begin
            if (!conflict) begin
                mem_m[b]  = bus.data_in_b;
                used_m[b] = 1'b1;
            end else if (free_idx >= 0) begin
                mem_m[free_idx]  = bus.data_in_b;
                used_m[free_idx] = 1'b1;
                exp_redir = 1'b1;
                exp_raddr = 8'(free_idx);
            end else begin
                exp_drop = 1'b1;
            end
        end
    endtask

    // One clock: model follows the edge, inputs may change 2 time units later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic idle();
        bus.write_enable_a  = 1'b0;
        bus.write_enable_b  = 1'b0;
        bus.output_enable_a = 1'b0;
        bus.output_enable_b = 1'b0;
    endtask

    task automatic conflict_wr(input logic [7:0] addr, input logic [7:0] da,
                               input logic [7:0] db);
        idle();
        bus.write_enable_a = 1'b1;
        bus.write_enable_b = 1'b1;
        bus.address_a      = addr;
        bus.address_b      = addr;
        bus.data_in_a      = da;
        bus.data_in_b      = db;
        tick();
        idle();
    endtask

    task automatic wr_a(input logic [7:0] addr, input logic [7:0] d);
        idle();
        bus.write_enable_a = 1'b1;
        bus.address_a      = addr;
        bus.data_in_a      = d;
        tick();
        idle();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_out_a", 32'(bus.data_out_a), 32'(exp_dout_a));
            chk("data_out_b", 32'(bus.data_out_b), 32'(exp_dout_b));
            chk("redirect_b", 32'(bus.redirect_b), 32'(exp_redir));
            chk("redirect_addr_b", 32'(bus.redirect_addr_b), 32'(exp_raddr));
            chk("drop_b", 32'(bus.drop_b), 32'(exp_drop));
        end
    end

    logic [7:0] snap [DEPTH];
    int         diffs;

    initial begin
        rst_n = 1'b0;
        idle();
        bus.address_a = '0;
        bus.address_b = '0;
        bus.data_in_a = '0;
        bus.data_in_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i]  = 8'h00;
            used_m[i] = 1'b0;
        end
        tick();
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // Give every word a known value, then clear the used flags again.
        for (int i = 0; i < DEPTH; i++) wr_a(8'(i), 8'(i) ^ 8'hA5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("used_after_reset", 32'($countones(dut.used_flag)), 32'd0);

        // Basic write then read, both ports
        wr_a(8'd10, 8'h55);
        bus.output_enable_a = 1'b1;
        bus.address_a       = 8'd10;
        tick();
        idle();
        chk("basic_read_a", 32'(bus.data_out_a), 32'h55);
        bus.write_enable_b = 1'b1;
        bus.address_b      = 8'd20;
        bus.data_in_b      = 8'h66;
        tick();
        idle();
        bus.output_enable_a = 1'b1;
        bus.address_a       = 8'd20;
        tick();
        idle();
        chk("basic_b_via_a", 32'(bus.data_out_a), 32'h66);

        // Conflict skipping used words 31 and 32
        wr_a(8'd30, 8'd99);
        wr_a(8'd31, 8'd111);
        wr_a(8'd32, 8'd113);
        conflict_wr(8'd30, 8'd100, 8'd200);
        chk("skip_redirect", 32'(bus.redirect_b), 32'd1);
        chk("skip_addr", 32'(bus.redirect_addr_b), 32'd33);
        chk("skip_mem30", 32'(dut.memory[30]), 32'd100);
        chk("skip_mem31", 32'(dut.memory[31]), 32'd111);
        chk("skip_mem32", 32'(dut.memory[32]), 32'd113);
        chk("skip_mem33", 32'(dut.memory[33]), 32'd200);
        tick();
        chk("redirect_pulse", 32'(bus.redirect_b), 32'd0);
        chk("redirect_addr_hold", 32'(bus.redirect_addr_b), 32'd33);

        // Conflict on free space
        conflict_wr(8'd35, 8'd120, 8'd220);
        chk("free_addr", 32'(bus.redirect_addr_b), 32'd36);
        chk("free_mem35", 32'(dut.memory[35]), 32'd120);
        chk("free_mem36", 32'(dut.memory[36]), 32'd220);

        // Read-first on a same-edge write
        wr_a(8'd5, 8'd1);
        bus.write_enable_a  = 1'b1;
        bus.address_a       = 8'd5;
        bus.data_in_a       = 8'd2;
        bus.output_enable_b = 1'b1;
        bus.address_b       = 8'd5;
        tick();
        idle();
        chk("read_first_old", 32'(bus.data_out_b), 32'd1);
        bus.output_enable_b = 1'b1;
        bus.address_b       = 8'd5;
        tick();
        idle();
        chk("read_first_new", 32'(bus.data_out_b), 32'd2);

        // Non-conflicting B write onto a used word stays in place
        bus.write_enable_a = 1'b1;
        bus.address_a      = 8'd40;
        bus.data_in_a      = 8'd88;
        bus.write_enable_b = 1'b1;
        bus.address_b      = 8'd30;
        bus.data_in_b      = 8'd77;
        tick();
        idle();
        chk("overwrite_no_redirect", 32'(bus.redirect_b), 32'd0);
        chk("overwrite_mem30", 32'(dut.memory[30]), 32'd77);
        chk("overwrite_mem40", 32'(dut.memory[40]), 32'd88);

        // Reset: request during reset is ignored, memory kept
        rst_n              = 1'b0;
        bus.write_enable_a = 1'b1;
        bus.address_a      = 8'd7;
        bus.data_in_a      = 8'hEE;
        tick();
        idle();
        rst_n = 1'b1;
        chk("rst_dout_a", 32'(bus.data_out_a), 32'd0);
        chk("rst_dout_b", 32'(bus.data_out_b), 32'd0);
        chk("rst_redirect_addr", 32'(bus.redirect_addr_b), 32'd0);
        chk("rst_used", 32'($countones(dut.used_flag)), 32'd0);
        chk("rst_mem5_kept", 32'(dut.memory[5]), 32'd2);
        chk("rst_write_ignored", 32'(dut.memory[7]), 32'(8'd7 ^ 8'hA5));

        // Wrap: only word 2 free, conflict at 255 lands there
        for (int i = 0; i < DEPTH; i++) if (i != 2) wr_a(8'(i), 8'(i + 3));
        conflict_wr(8'd255, 8'd1, 8'h42);
        chk("wrap_redirect", 32'(bus.redirect_b), 32'd1);
        chk("wrap_addr", 32'(bus.redirect_addr_b), 32'd2);
        chk("wrap_mem2", 32'(dut.memory[2]), 32'h42);

        // Full: B dropped, only A's word changes
        for (int i = 0; i < DEPTH; i++) snap[i] = mem_m[i];
        conflict_wr(8'd100, 8'h11, 8'h22);
        chk("full_drop", 32'(bus.drop_b), 32'd1);
        chk("full_no_redirect", 32'(bus.redirect_b), 32'd0);
        chk("full_mem100", 32'(dut.memory[100]), 32'h11);
        diffs = 0;
        for (int i = 0; i < DEPTH; i++) if (i != 100 && dut.memory[i] !== snap[i]) diffs++;
        chk("full_others_unchanged", 32'(diffs), 32'd0);
        tick();
        chk("drop_pulse", 32'(bus.drop_b), 32'd0);

        // Randomised traffic, clustered addresses to provoke conflicts and long searches
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            rst_n               = ($urandom_range(0, 199) != 0);
            bus.write_enable_a  = 1'($urandom_range(0, 1));
            bus.write_enable_b  = 1'($urandom_range(0, 1));
            bus.output_enable_a = 1'($urandom_range(0, 1));
            bus.output_enable_b = 1'($urandom_range(0, 1));
            bus.address_a       = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                              : 8'($urandom_range(0, 31));
            bus.address_b       = ($urandom_range(0, 2) == 0) ? bus.address_a
                                                              : 8'($urandom_range(0, 31));
            bus.data_in_a       = 8'($urandom);
            bus.data_in_b       = 8'($urandom);
            tick();
        end
        rst_n = 1'b1;
        idle();
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            chk("final_mem", 32'(dut.memory[i]), 32'(mem_m[i]));
            chk("final_used", 32'(dut.used_flag[i]), 32'(used_m[i]));
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
